reg_pipe: RTL and testbench
===========================

Name: reg_pipe

Overview:
Parametrised elastic pipeline register: a chain of DEPTH WIDTH-bit register stages with valid/ready handshakes at both ends. It provides full throughput, bubble collapsing and a synchronous flush. It replaces hand-instantiated chains of fixed 8-bit enable registers on datapaths between blocks that can stall. Each stage loads only on an accepted transfer, so it keeps enable-register semantics per stage.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 2, number of register stages (>=1)
RESET_VAL, 0, value loaded into every data register on RST/CLR (WIDTH bits)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
CLR  in  1  synchronous flush, active-high
IN_VALID  in  1  upstream data valid
IN_READY  out  1  block can accept IN this cycle
IN  in  WIDTH  upstream data
OUT_VALID  out  1  OUT holds valid data (last stage valid)
OUT_READY  in  1  downstream accepts OUT this cycle
OUT  out  WIDTH  data of last stage (stage DEPTH-1)
COUNT  out  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- State per stage i (0 = input side, DEPTH-1 = output side): valid flag v[i] and data register d[i].
- Reset (RST high, async): all v[i]=0, all d[i]=RESET_VAL, OUT=RESET_VAL, OUT_VALID=0, COUNT=0. IN_READY=1 once RST deasserts (if CLR low).
- Advance rule, combinational, evaluated from the output end:
  - adv[DEPTH-1] = v[DEPTH-1] & OUT_READY.
  - For i<DEPTH-1: space[i+1] = !v[i+1] | adv[i+1]; adv[i] = v[i] & space[i+1].
  - IN_READY = (!v[0] | adv[0]) & !CLR.
  - In the ready path, stage i is open whenever stage i+1 is empty or advancing (bubble collapse).
- Per clock edge (CLR low), for each stage i:
  - If i receives (from IN with IN_VALID&IN_READY for i=0; from adv[i-1] otherwise): d[i] <= incoming data, v[i] <= 1.
  - Else if adv[i]: v[i] <= 0, d[i] holds.
  - Else: hold.
  - d[i] is never written except on receive. Data never overtakes and order is preserved.
- Latency: an item accepted at edge N appears on OUT with OUT_VALID=1 after edge N+DEPTH-1, i.e. DEPTH cycles from acceptance, when unstalled. Throughput is 1 item/cycle sustained.
- Stall: while OUT_VALID=1 and OUT_READY=0, OUT is stable. Upstream stages keep filling until all DEPTH stages are valid, then IN_READY=0.
- Full with OUT_READY=1: IN_READY=1 in the same cycle (pass-through ready chain, no dead cycle).
- Empty: OUT_VALID=0 and OUT=last loaded value (or RESET_VAL). OUT_READY is ignored.
- COUNT = popcount(v) and is registered-state derived; it updates the edge after each transfer. It is incremented on input accept and decremented on output accept. If both happen in one cycle, COUNT is unchanged.
- CLR (sync, priority over handshakes): IN_READY forced 0, so no input is accepted. At the edge, all v<=0 and all d<=RESET_VAL. An OUT_VALID&OUT_READY handshake during the CLR cycle counts as delivered to downstream; all other contents are discarded.
- RST asserted mid-operation: immediate clear as at reset, with in-flight data lost. The first accept after deassert behaves as from empty.
- DEPTH=1: single elastic register. IN_READY = !v[0] | OUT_READY.

Test Plan:
- Reset: WIDTH=8, DEPTH=3, RESET_VAL=8'hA5, assert RST mid-cycle -> OUT=8'hA5, OUT_VALID=0, COUNT=0 immediately, without waiting for CLK; IN_READY=1 after release.
- Streaming: OUT_READY=1, send 0x01..0x08 back-to-back -> IN_READY stays 1; OUT_VALID rises 3 cycles after first accept; OUT=0x01..0x08 on consecutive cycles; COUNT peaks at 3.
- Backpressure: OUT_READY=0, offer 0x10,0x11,0x12,0x13 -> first three accepted, IN_READY=0 with 0x13 pending; COUNT=3; OUT=0x10 stable. Raise OUT_READY -> in the same cycle IN_READY=1; 0x13 accepted; outputs 0x10,0x11,0x12,0x13 in order.
- Bubble collapse: OUT_READY=0, send one item 0x42 -> after 3 cycles it sits in the last stage, OUT=0x42, OUT_VALID=1, COUNT=1, IN_READY=1; two more accepts raise COUNT to 3.
- Flush: pipeline holds 0x20,0x21,0x22 with OUT_READY=1 and CLR for one cycle -> 0x20 delivered that cycle; IN_READY=0 during CLR; next cycle COUNT=0, OUT_VALID=0, OUT=RESET_VAL; 0x21/0x22 never appear.
- DEPTH=1, WIDTH=16: alternate OUT_READY every cycle with continuous IN_VALID -> no item lost or duplicated; IN_READY=1 whenever the register is empty or OUT_READY=1.

Source files
------------

// File: rtl/reg_pipe.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble
// collapse, pass-through ready chain and synchronous flush.
module reg_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic [CW-1:0]    COUNT
);

  logic [DEPTH-1:0] vv;

  for (genvar g = 0; g < DEPTH; g++) begin : st
    logic             v;
    logic             adv;
    logic             rx;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] din;

    // Ready chain is evaluated from the output end
    if (g == DEPTH - 1) begin : g_last
      assign adv = v & OUT_READY;
    end else begin : g_mid
      assign adv = v & (!st[g+1].v | st[g+1].adv);
    end

    if (g == 0) begin : g_first
      assign rx  = IN_VALID & IN_READY;
      assign din = IN;
    end else begin : g_rest
      assign rx  = st[g-1].adv;
      assign din = st[g-1].d;
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        v <= 1'b0;
        d <= RESET_VAL;
      end else if (CLR) begin
        v <= 1'b0;
        d <= RESET_VAL;
      end else if (rx) begin
        v <= 1'b1;
        d <= din;
      end else if (adv) begin
        v <= 1'b0;
      end
    end

    assign vv[g] = v;
  end

  assign IN_READY  = (!st[0].v | st[0].adv) & !CLR;
  assign OUT_VALID = st[DEPTH-1].v;
  assign OUT       = st[DEPTH-1].d;

  always_comb begin
    COUNT = '0;
    for (int i = 0; i < DEPTH; i++) begin
      COUNT = COUNT + CW'(vv[i]);
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe: DEPTH=3 instance plus a DEPTH=1
// instance, with a queue scoreboard on each output.
module tb_reg_pipe;

  logic        CLK;
  logic        RST;
  logic        CLR;
  logic        iv, ir, ov, ordy;
  logic [7:0]  din, dout;
  logic [1:0]  cnt;
  logic        iv1, ir1, ov1, ordy1;
  logic [15:0] din1, dout1;
  logic [0:0]  cnt1;

  int checks;
  int failures;
  int npop1;
  logic [7:0]  q[$];
  logic [15:0] q1[$];

  reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .IN_VALID(iv), .IN_READY(ir), .IN(din),
    .OUT_VALID(ov), .OUT_READY(ordy), .OUT(dout),
    .COUNT(cnt)
  );

  reg_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) dut1 (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .IN_VALID(iv1), .IN_READY(ir1), .IN(din1),
    .OUT_VALID(ov1), .OUT_READY(ordy1), .OUT(dout1),
    .COUNT(cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample handshakes at the falling edge, then advance one cycle
  task automatic step();
    @(negedge CLK);
    if (!RST) begin
      if (iv && ir) q.push_back(din);
      if (ov && ordy) begin
        chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) chk("sb_out", 32'(dout), 32'(q.pop_front()));
      end
      if (iv1 && ir1) q1.push_back(din1);
      if (ov1 && ordy1) begin
        npop1++;
        chk("sb1_nonempty", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) chk("sb1_out", 32'(dout1), 32'(q1.pop_front()));
      end
      if (CLR) begin
        q.delete();
        q1.delete();
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic full1;
    int   nsent;
    logic exp_ir1;
    checks = 0;
    failures = 0;
    npop1 = 0;
    RST = 1'b1;
    CLR = 1'b0;
    iv = 1'b0; din = '0; ordy = 1'b0;
    iv1 = 1'b0; din1 = '0; ordy1 = 1'b0;

    #2;
    chk("rst_out", 32'(dout), 32'hA5);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    #1 chk("rst_ir", 32'(ir), 32'd1);

    // Streaming
    ordy = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      iv = 1'b1;
      din = 8'(k);
      #1 chk("stream_ir", 32'(ir), 32'd1);
      step();
      chk("stream_ov", 32'(ov), 32'(k >= 3));
      chk("stream_cnt", 32'(cnt), 32'(k >= 3 ? 3 : k));
    end
    iv = 1'b0;
    repeat (5) step();
    chk("stream_drain_q", 32'(q.size()), 32'd0);
    chk("stream_drain_cnt", 32'(cnt), 32'd0);

    // Backpressure
    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv = 1'b1;
      din = 8'h10 + 8'(k);
      #1 chk("bp_ir", 32'(ir), 32'(k < 3));
      step();
    end
    chk("bp_cnt", 32'(cnt), 32'd3);
    chk("bp_ov", 32'(ov), 32'd1);
    chk("bp_out", 32'(dout), 32'h10);
    step();
    chk("bp_out_stable", 32'(dout), 32'h10);
    ordy = 1'b1;
    #1 chk("bp_passthru_ir", 32'(ir), 32'd1);
    step();
    iv = 1'b0;
    repeat (5) step();
    chk("bp_drain_q", 32'(q.size()), 32'd0);
    chk("bp_drain_cnt", 32'(cnt), 32'd0);

    // Bubble collapse
    ordy = 1'b0;
    iv = 1'b1;
    din = 8'h42;
    step();
    iv = 1'b0;
    repeat (2) step();
    chk("bub_ov", 32'(ov), 32'd1);
    chk("bub_out", 32'(dout), 32'h42);
    chk("bub_cnt", 32'(cnt), 32'd1);
    chk("bub_ir", 32'(ir), 32'd1);
    iv = 1'b1;
    din = 8'h43;
    step();
    din = 8'h44;
    #1 chk("bub_ir2", 32'(ir), 32'd1);
    step();
    iv = 1'b0;
    chk("bub_cnt3", 32'(cnt), 32'd3);
    ordy = 1'b1;
    repeat (5) step();
    chk("bub_drain_q", 32'(q.size()), 32'd0);

    // Flush
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1;
      din = 8'h20 + 8'(k);
      step();
    end
    iv = 1'b0;
    chk("fl_out_pre", 32'(dout), 32'h20);
    ordy = 1'b1;
    CLR = 1'b1;
    iv = 1'b1;
    din = 8'h2F;
    #1 chk("fl_ir", 32'(ir), 32'd0);
    step();
    CLR = 1'b0;
    iv = 1'b0;
    chk("fl_cnt", 32'(cnt), 32'd0);
    chk("fl_ov", 32'(ov), 32'd0);
    chk("fl_out", 32'(dout), 32'hA5);
    repeat (4) step();
    chk("fl_quiet", 32'(ov), 32'd0);

    // Reset mid-operation
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1;
      din = 8'h55 + 8'(k);
      step();
    end
    iv = 1'b0;
    chk("mrst_pre_out", 32'(dout), 32'h55);
    #3 RST = 1'b1;
    #1;
    chk("mrst_out", 32'(dout), 32'hA5);
    chk("mrst_ov", 32'(ov), 32'd0);
    chk("mrst_cnt", 32'(cnt), 32'd0);
    q.delete();
    q1.delete();
    @(posedge CLK); #1;
    RST = 1'b0;
    #1 chk("mrst_ir", 32'(ir), 32'd1);
    ordy = 1'b1;
    iv = 1'b1;
    din = 8'h66;
    step();
    iv = 1'b0;
    step();
    chk("mrst_lat_ov", 32'(ov), 32'd0);
    step();
    chk("mrst_first_ov", 32'(ov), 32'd1);
    chk("mrst_first_out", 32'(dout), 32'h66);
    repeat (3) step();
    chk("mrst_drain_q", 32'(q.size()), 32'd0);

    // DEPTH=1 with alternating OUT_READY
    full1 = 1'b0;
    nsent = 0;
    npop1 = 0;
    iv1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      ordy1 = c[0];
      din1 = 16'hA000 + 16'(nsent);
      exp_ir1 = !full1 | ordy1;
      #1;
      chk("d1_ir", 32'(ir1), 32'(exp_ir1));
      chk("d1_ov", 32'(ov1), 32'(full1));
      chk("d1_cnt", 32'(cnt1), 32'(full1));
      step();
      if (exp_ir1) begin
        nsent++;
        full1 = 1'b1;
      end else if (full1 && ordy1) begin
        full1 = 1'b0;
      end
    end
    iv1 = 1'b0;
    ordy1 = 1'b1;
    repeat (3) step();
    chk("d1_drain_q", 32'(q1.size()), 32'd0);
    chk("d1_count", 32'(npop1), 32'(nsent));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
